// File: rtl/wr_pack_ctrl.sv
// Write-data packing sequencer: steers an external 8-to-32 packer and issues word writes.
// Optional sticky packer-full error checking is enabled by defining WRPACK_FULL_CHECK_EN.
module wr_pack_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              pk_rst,
  output logic              pk_ld,
  output logic              pk_pad,
  input  logic              pk_full,
  input  logic [31:0]       pk_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_written,
`ifdef WRPACK_FULL_CHECK_EN
  output logic              err,
`endif
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid & in_ready are both 1;
  // in_ready depends only on the current state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FILL  = 3'd2,
    S_PAD   = 3'd3,
    S_CAPT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t              state_q, state_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic                last_seen_q, last_seen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   words_q, words_d;
  logic                err_q, err_d;
  logic                accept;

  assign accept = (state_q == S_FILL) && in_valid;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    last_seen_d = last_seen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d  = base_addr;
          words_d     = '0;
          last_seen_d = 1'b0;
          err_d       = 1'b0;
          state_d     = S_CLR;
        end
      end
      S_CLR: begin
        byte_cnt_d = 3'd0;
        state_d    = S_FILL;
      end
      S_FILL: begin
`ifdef WRPACK_FULL_CHECK_EN
        if (pk_full) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else
`endif
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
            state_d = S_CAPT;
            if (in_last) last_seen_d = 1'b1;
          end else if (in_last) begin
            last_seen_d = 1'b1;
            state_d     = S_PAD;
          end
        end
      end
      S_PAD: begin
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'd3) state_d = S_CAPT;
      end
      S_CAPT: begin
`ifdef WRPACK_FULL_CHECK_EN
        if (!pk_full) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          mem_wdata_d = pk_data;
          byte_cnt_d  = 3'd0;
          state_d     = S_WRITE;
        end
`else
        mem_wdata_d = pk_data;
        byte_cnt_d  = 3'd0;
        state_d     = S_WRITE;
`endif
      end
      S_WRITE: begin
        if (mem_ack) begin
          mem_addr_d = mem_addr_q + STEP;
          words_d    = words_q + ADDR_W'(1);
          state_d    = last_seen_q ? S_DONE : S_FILL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 3'd0;
      last_seen_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      last_seen_q <= last_seen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
      err_q       <= err_d;
    end
  end

  // Controls are decoded from the registered state; only pk_ld follows in_valid in FILL.
  assign in_ready      = (state_q == S_FILL);
  assign pk_ld         = accept || (state_q == S_PAD);
  assign pk_pad        = (state_q == S_PAD);
  assign pk_rst        = (state_q == S_IDLE) || (state_q == S_CLR) || (state_q == S_CAPT);
  assign mem_req       = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign words_written = words_q;
  assign dbg_state     = state_q;

`ifdef WRPACK_FULL_CHECK_EN
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wr_pack_ctrl.sv
// Bench for wr_pack_ctrl: packer model, acking memory responder, write scoreboard, run table.
module tb_wr_pack_ctrl;
  localparam int ADDR_W = 16;
  localparam int W      = ADDR_W + 32;

  logic              clk, rst_n, start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid, in_last, in_ready;
  logic [7:0]        in_data;
  logic              pk_rst, pk_ld, pk_pad, pk_full;
  logic [31:0]       pk_data;
  logic              mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr, words_written;
  logic [31:0]       mem_wdata;
  logic              busy, done;
  logic [2:0]        dbg_state;
`ifdef WRPACK_FULL_CHECK_EN
  logic              err;
`endif

  wr_pack_ctrl #(.ADDR_W(ADDR_W), .ADDR_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .pk_rst(pk_rst), .pk_ld(pk_ld), .pk_pad(pk_pad), .pk_full(pk_full), .pk_data(pk_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .words_written(words_written),
`ifdef WRPACK_FULL_CHECK_EN
    .err(err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // packer model: shifts bytes in MSB-first, full after four loads
  logic [2:0]  pk_cnt;
  logic [31:0] pk_sr;
  logic        full_kill;
  always @(posedge clk) begin
    if (pk_rst) begin
      pk_cnt <= 3'd0;
      pk_sr  <= 32'h0;
    end else if (pk_ld) begin
      pk_sr  <= {pk_sr[23:0], (pk_pad ? 8'h00 : in_data)};
      pk_cnt <= pk_cnt + 3'd1;
    end
  end
  assign pk_full = (pk_cnt == 3'd4) && !full_kill;
  assign pk_data = pk_sr;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  int pad_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // memory responder + monitor, evaluated away from the active edge
  initial begin
    int           wcnt;
    logic         hold_v;
    logic [W-1:0] held, e;
    mem_ack = 1'b0;
    wcnt    = 0;
    hold_v  = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        check("in_ready_low_in_write", 64'(in_ready), 64'd0);
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          wcnt    = 0;
          hold_v  = 1'b0;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write actual=%0h@%0h required=none", mem_wdata, mem_addr);
          end else begin
            e = exp_q.pop_front();
            check("write_addr_data", 64'({mem_addr, mem_wdata}), 64'(e));
          end
        end else begin
          mem_ack = 1'b0;
          wcnt++;
          if (hold_v) check("req_stable", 64'({mem_addr, mem_wdata}), 64'(held));
          else begin
            held   = {mem_addr, mem_wdata};
            hold_v = 1'b1;
          end
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
        hold_v  = 1'b0;
      end
      if (pk_pad) pad_cnt++;
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic drive_byte(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout actual=in_ready0 required=in_ready1");
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  typedef struct {
    logic [15:0] base;
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    int          ack_delay;
    logic        glitch;
    int          exp_words;
    int          exp_pads;
  } run_t;

  task automatic run(input run_t r);
    logic [31:0] w;
    logic [7:0]  b;
    int          idx;
    ack_delay = r.ack_delay;
    pad_cnt   = 0;
    done_cnt  = 0;
    for (int j = 0; j < (r.n + 3) / 4; j++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        idx = 4 * j + k;
        b   = (idx < r.n) ? 8'(r.first + 8'(idx) * r.step) : 8'h00;
        w   = {w[23:0], b};
      end
      exp_q.push_back({16'(r.base + 16'(j)), w});
    end
    pulse_start(r.base);
    for (int i = 0; i < r.n; i++) begin
      if (r.glitch && i == 2) begin
        start     = 1'b1;
        base_addr = 16'h1234;
      end
      drive_byte(8'(r.first + 8'(i) * r.step), (i == r.n - 1));
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("words_written", 64'(words_written), 64'(r.exp_words));
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("pad_cycles", 64'(pad_cnt), 64'(r.exp_pads));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  run_t runs[7];

  initial begin
    runs[0] = '{16'h0100, 8, 8'h11, 8'h11, 0, 1'b0, 2, 0};
    runs[1] = '{16'h0000, 5, 8'hA1, 8'h01, 0, 1'b0, 2, 3};
    runs[2] = '{16'h0200, 8, 8'h01, 8'h01, 3, 1'b0, 2, 0};
    runs[3] = '{16'hFFFF, 8, 8'h30, 8'h01, 0, 1'b1, 2, 0};
    runs[4] = '{16'h0010, 1, 8'h5A, 8'h01, 1, 1'b0, 1, 3};
    runs[5] = '{16'h0020, 7, 8'hC0, 8'h01, 2, 1'b0, 2, 1};
    runs[6] = '{16'h0030, 4, 8'hF0, 8'h01, 0, 1'b0, 1, 0};

    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; full_kill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pk_rst", 64'(pk_rst), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr_data_words", 64'({mem_addr, mem_wdata, words_written}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(runs[i]);

    repeat (5) @(negedge clk);
    check("words_hold_after_done", 64'(words_written), 64'd1);

    // reset while a write is outstanding
    ack_delay = 1000;
    pulse_start(16'h0400);
    for (int i = 0; i < 4; i++) drive_byte(8'h60 + 8'(i), 1'b0);
    begin
      int t = 0;
      while (!mem_req && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("reach_write", 64'(mem_req), 64'd1);
    end
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pk_rst", 64'(pk_rst), 64'd1);
    check("abort_words", 64'(words_written), 64'd0);
    check("abort_addr", 64'(mem_addr), 64'd0);
    run('{16'h0500, 4, 8'hD1, 8'h01, 0, 1'b0, 1, 0});

`ifdef WRPACK_FULL_CHECK_EN
    full_kill = 1'b1;
    ack_delay = 0;
    done_cnt  = 0;
    pulse_start(16'h0600);
    for (int i = 0; i < 4; i++) drive_byte(8'h70 + 8'(i), 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    check("err_set", 64'(err), 64'd1);
    check("err_done_pulses", 64'(done_cnt), 64'd1);
    check("err_no_words", 64'(words_written), 64'd0);
    full_kill = 1'b0;
    run('{16'h0700, 4, 8'h81, 8'h01, 0, 1'b0, 1, 0});
    check("err_cleared_by_start", 64'(err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wr_pack_ctrl.md
Name: wr_pack_ctrl

Overview:
- Sequences the 8-to-32-bit write-data packing register in the CNN output path.
- Accepts the PE output byte stream with a valid/ready handshake and drives the packer's reset, load and zero-pad controls.
- Captures each full 32-bit word and issues it as a write request with an auto-incrementing address.
- Zero-pads the final partial word when the stream ends mid-word, then pulses done.

Parameters:
ADDR_W, 16, width of the memory word address and of the word counter.
ADDR_STEP, 1, address increment applied after each acknowledged word write.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse that begins a packing run; sampled only in IDLE
base_addr  input  ADDR_W  first word address; latched on start
in_valid  input  1  byte stream valid
in_data  input  8  byte stream data; forwarded to the packer byte input
in_last  input  1  marks the final byte of the run; qualified by in_valid
in_ready  output  1  controller accepts a byte this cycle
pk_rst  output  1  packer counter clear (packer's active-high reset)
pk_ld  output  1  packer load strobe
pk_pad  output  1  packer last/pad select; 1 shifts in 8'h00 instead of in_data
pk_full  input  1  packer full flag (4 bytes loaded)
pk_data  input  32  packer word output; valid only while pk_full=1
mem_req  output  1  write request; held until mem_ack
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  write data (registered)
mem_ack  input  1  write accepted this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of run
words_written  output  ADDR_W  words acknowledged in the current run; holds after done until next start

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, byte_cnt=0, last_seen=0, mem_addr=0, mem_wdata=0, words_written=0, done=0. In IDLE: pk_rst=1, in_ready=0, pk_ld=0, pk_pad=0, mem_req=0, busy=0. Reset mid-run aborts immediately: no further requests, and the partial word is discarded.
- States: IDLE, CLR, FILL, PAD, CAPT, WRITE, DONE.
- IDLE: on start, latch base_addr into mem_addr, clear words_written and last_seen, go to CLR. start in any other state is ignored.
- CLR: pk_rst=1 for one cycle, byte_cnt=0, go to FILL.
- FILL: in_ready=1. pk_ld = in_valid & in_ready, pk_pad=0. On each accepted byte, byte_cnt++.
  - 4th byte accepted (byte_cnt 3->4): go to CAPT. If in_last is set on that byte, set last_seen.
  - in_last accepted with byte_cnt<4 after the increment: set last_seen, go to PAD.
- PAD: in_ready=0, pk_ld=1, pk_pad=1 each cycle until byte_cnt reaches 4, then go to CAPT. The run pads 1..3 bytes.
- CAPT (pk_full=1 here): mem_wdata<=pk_data, pk_rst=1, byte_cnt<=0, go to WRITE.
- WRITE: mem_req=1. mem_addr and mem_wdata are stable until mem_ack.
  - On mem_ack: mem_addr+=ADDR_STEP (wraps modulo 2^ADDR_W), words_written++.
  - If last_seen, go to DONE; else go to FILL.
  - mem_ack while mem_req=0 is ignored.
- DONE: done=1 for one cycle, go to IDLE.
- Byte order: first byte of a word lands in [31:24], fourth in [7:0]; pad bytes fill the low positions.
- Latency: 4th byte accepted at edge N; CAPT during cycle N+1; mem_req high from cycle N+2. After mem_ack, in_ready is high the next cycle.
- in_ready is 0 in every state except FILL. An in_valid byte presented outside FILL is not consumed.
- A run whose byte count is a multiple of 4 emits no pad word.

Optional Feature:
- Macro: WRPACK_FULL_CHECK_EN.
- With the macro defined:
  - Adds output err (1 bit, reset 0).
  - If pk_full=0 in CAPT, err is set (sticky until reset or next start), no write is issued, and the FSM goes to DONE.
  - If pk_full=1 in FILL, the same error is raised.
- Without the macro: no err port. CAPT latches pk_data unconditionally.

Test Plan:
- 8 bytes 0x11..0x88, in_last on 0x88, base_addr=0x0100, mem_ack same cycle as req -> writes 0x11223344@0x0100 and 0x55667788@0x0101, done pulse, words_written=2, pk_pad never high.
- 5 bytes 0xA1..0xA5, last on 0xA5, base 0x0000 -> 0xA1A2A3A4@0x0000, then 3 pad loads, 0xA5000000@0x0001, done, words_written=2.
- mem_ack delayed 3 cycles, in_valid held high -> mem_req/mem_addr/mem_wdata stable for 3 cycles, in_ready=0 throughout, no byte lost (next word correct).
- base_addr=0xFFFF, 8 bytes -> second write at 0x0000 (wrap). start pulsed while busy -> ignored, mem_addr sequence unchanged.
- rst_n low for 1 cycle during WRITE -> next cycle mem_req=0, busy=0, pk_rst=1. A fresh start then packs from byte_cnt=0.
- WRPACK_FULL_CHECK_EN defined, pk_full forced 0 -> after the 4th byte, err=1, no mem_req, done pulses.
